// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_RUN,
    IFU_HALT
  } ifu_state_t;

  localparam logic [31:0] IFU_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] IFU_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] IFU_PC_INC    = 32'd4;

endpackage

// File: rtl/ifu_if.sv
// Instruction handshake between the fetch unit (master) and the CPU (slave).
interface ifu_if;

  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/ifu_imem.sv
// Instruction memory: 2**ADDR_W x 32, synchronous write, combinational read.
module ifu_imem #(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch FSM, PC and registered instruction slot in front of ifu_imem.
// Optional handshake counter on fetch_count when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] RESET_PC  = IFU_RESET_PC,
  parameter logic [31:0] HALT_WORD = IFU_HALT_WORD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  ifu_if.master             ibus,
  output logic              halted,
  output logic              busy
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  ifu_state_t  state;
  logic [31:0] pc;
  logic [31:0] word;
  logic [31:0] instr_q;
  logic [31:0] instr_pc_q;
  logic        valid_q;
  logic        slot_free;
  logic        handshake;
  logic        out_of_range;
  logic        mem_we;

  assign handshake    = valid_q & ibus.instr_ready;
  assign slot_free    = ~valid_q | ibus.instr_ready;
  // Any PC bit above the word index means the fetch lies past the last word.
  assign out_of_range = |pc[31:ADDR_W+2];
  assign mem_we       = load_valid & (state != IFU_RUN);

  ifu_imem #(.ADDR_W(ADDR_W)) u_imem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc[ADDR_W+1:2]),
    .rdata (word)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IFU_IDLE;
      pc         <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      halted     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IFU_IDLE, IFU_HALT: begin
          if (start) begin
            state  <= IFU_RUN;
            pc     <= RESET_PC;
            halted <= 1'b0;
            busy   <= 1'b1;
          end
        end
        IFU_RUN: begin
          // A redirect wins over fetch; an accepted word this cycle is already consumed.
          if (redirect_valid) begin
            pc      <= redirect_pc & ~32'd3;
            valid_q <= 1'b0;
          end else if (slot_free) begin
            if (word == HALT_WORD || out_of_range) begin
              state   <= IFU_HALT;
              valid_q <= 1'b0;
              halted  <= 1'b1;
              busy    <= 1'b0;
            end else begin
              instr_q    <= word;
              instr_pc_q <= pc;
              valid_q    <= 1'b1;
              pc         <= pc + IFU_PC_INC;
            end
          end
        end
        default: state <= IFU_IDLE;
      endcase
    end
  end

  assign ibus.instr_valid = valid_q;
  assign ibus.instr       = instr_q;
  assign ibus.instr_pc    = instr_pc_q;

`ifdef IFU_PERF_CNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (state != IFU_RUN && start) begin
      count_q <= '0;
    end else if (handshake && count_q != '1) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign fetch_count = count_q;
`else
  logic unused_handshake;
  assign unused_handshake = handshake;
`endif

endmodule
